snake_dir_ctrl: RTL

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

---
 rtl/snake_dir_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: per-button debounce, priority request capture and
// tick-driven direction updates that reject reversals. Define DIR_QUEUE_EN for a
// two-entry request FIFO; without it a single overwrite-on-press slot is used.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       dir_update,
    output logic       pending
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       acc;
    logic             press_vld;
    logic [1:0]       press_req;

    logic [1:0] dir_q, dir_d;
    logic       dir_update_q, dir_update_d;
    logic       head_vld;
    logic [1:0] head_req;
    logic       pop;

    // A press fires only on the transition into saturation, so holding is silent.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            acc[i] = btn[i] && (cnt_q[i] == CNT_ACC);
            if (!btn[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_comb begin
        press_vld = |acc;
        press_req = 2'b11;
        if (acc[3]) begin
            press_req = 2'b00;
        end else if (acc[2]) begin
            press_req = 2'b01;
        end else if (acc[1]) begin
            press_req = 2'b10;
        end
    end

    // Reversal is the direction differing only in bit 0 (up/down, left/right).
    always_comb begin
        pop          = tick && head_vld;
        dir_d        = dir_q;
        dir_update_d = 1'b0;
        if (pop && (head_req != dir_q) && (head_req != (dir_q ^ 2'b01))) begin
            dir_d        = head_req;
            dir_update_d = 1'b1;
        end
    end

`ifdef DIR_QUEUE_EN
    logic [1:0] q0_q, q0_d;
    logic [1:0] q1_q, q1_d;
    logic [1:0] fifo_cnt_q, fifo_cnt_d;

    assign head_vld = (fifo_cnt_q != 2'd0);
    assign head_req = q0_q;

    // Pop is applied before push so a full FIFO can accept a press on a tick edge.
    always_comb begin
        q0_d       = q0_q;
        q1_d       = q1_q;
        fifo_cnt_d = fifo_cnt_q;
        if (pop) begin
            q0_d       = q1_q;
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
        if (press_vld) begin
            if (fifo_cnt_d == 2'd0) begin
                q0_d       = press_req;
                fifo_cnt_d = 2'd1;
            end else if (fifo_cnt_d == 2'd1) begin
                q1_d       = press_req;
                fifo_cnt_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q       <= 2'b00;
            q1_q       <= 2'b00;
            fifo_cnt_q <= 2'd0;
        end else begin
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end
`else
    logic [1:0] req_q, req_d;
    logic       req_vld_q, req_vld_d;

    assign head_vld = req_vld_q;
    assign head_req = req_q;

    always_comb begin
        req_d     = req_q;
        req_vld_d = req_vld_q && !pop;
        if (press_vld) begin
            req_d     = press_req;
            req_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= 2'b00;
            req_vld_q <= 1'b0;
        end else begin
            req_q     <= req_d;
            req_vld_q <= req_vld_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            dir_q        <= 2'b11;
            dir_update_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dir_q        <= dir_d;
            dir_update_q <= dir_update_d;
        end
    end

    assign dir        = dir_q;
    assign dir_update = dir_update_q;
    assign pending    = head_vld;

endmodule
